// File: rtl/sort_pkg.sv
// Shared definitions for the sort pipeline and its unloader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sort_pkg;

    // Default geometry of the sort pipeline: element width and elements per vector.
    localparam int SORT_WIDTH       = 8;
    localparam int SORT_INDEX       = 8;
    localparam int SORT_INDEX_WIDTH = 3;

    // Unloader control states.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } unload_state_t;

endpackage : sort_pkg

// File: rtl/sort_unloader.sv
// Captures one sorted vector and streams it out one element per beat, ascending or descending.
// Latency: first element valid 1 cycle after capture; sustained 1 element/cycle with no bubble between vectors.
// Backpressure: out_ready stalls the stream; in_ready only opens in IDLE or on the last accepted beat.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_data           sorted vector, element 0 is the minimum
//   in_valid/in_ready capture handshake (in_ready depends combinationally on out_ready)
//   descending        emission order, sampled only at capture
//   out_data/out_idx  current element and its position in the emitted sequence
//   out_valid/out_ready stream handshake; out_last marks the final element
//   busy              a captured vector is still being emitted
module sort_unloader
    import sort_pkg::*;
#(
    parameter int width       = SORT_WIDTH,
    parameter int index       = SORT_INDEX,
    parameter int index_width = SORT_INDEX_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [0:index-1][width-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          descending,
    output logic [width-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [index_width-1:0]        out_idx,
    output logic                          out_last,
    output logic                          busy
);

    localparam logic [index_width-1:0] LAST_IDX = index_width'(index - 1);

    unload_state_t                 state_q;
    unload_state_t                 state_d;
    logic [index_width-1:0]        cnt_q;
    logic [0:index-1][width-1:0]   buf_q;
    logic                          desc_q;

    logic                          capture;
    logic                          xfer;
    logic [index_width-1:0]        sel_idx;

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        capture   = 1'b0;
        xfer      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                capture  = in_valid;
                if (capture) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                out_last  = (cnt_q == LAST_IDX);
                xfer      = out_ready;
                // The holding buffer frees up exactly as its last element leaves,
                // so a waiting vector can be loaded in that same cycle.
                in_ready  = out_last && out_ready;
                capture   = in_valid && in_ready;
                if (xfer && out_last && !capture) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Holding buffer, captured order and beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            desc_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (capture) begin
                buf_q  <= in_data;
                desc_q <= descending;
                cnt_q  <= '0;
            end else if (xfer) begin
                // Last beat without a new capture returns to IDLE; counter
                // is cleared so out_idx reads 0 while idle.
                cnt_q <= out_last ? '0 : cnt_q + index_width'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mux
    // ------------------------------------------------------------------
    assign sel_idx = desc_q ? (LAST_IDX - cnt_q) : cnt_q;

    always_comb begin
        out_data = '0;
        if (state_q == STREAM) begin
            out_data = buf_q[sel_idx];
        end
    end

    assign out_idx = cnt_q;
    assign busy    = (state_q == STREAM);

endmodule : sort_unloader

// File: tb/tb_sort_unloader.sv
module tb_sort_unloader;
    import sort_pkg::*;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int IW = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [0:N-1][W-1:0]   in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  descending;
    logic [W-1:0]          out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IW-1:0]         out_idx;
    logic                  out_last;
    logic                  busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    sort_unloader #(
        .width       (W),
        .index       (N),
        .index_width (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .descending (descending),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge (input drive point).
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Fill in_data with base, base+1, ..., base+N-1 (element 0 first).
    task automatic load_vec(input int base);
        for (int i = 0; i < N; i++) begin
            in_data[i] = W'(base + i);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        descending = 1'b0;
        in_data    = '0;
        settle();
        settle();
        @(negedge clk);
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid: got %0b exp 0", out_valid); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %0b exp 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL post_rst_in_ready: got %0b exp 1", in_ready); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL post_rst_out_valid: got %0b exp 0", out_valid); end
        vec_cnt++; if (out_data !== 8'd0) begin err_cnt++; $display("FAIL idle_out_data: got %0d exp 0", out_data); end
        vec_cnt++; if (out_last !== 1'b0) begin err_cnt++; $display("FAIL idle_out_last: got %0b exp 0", out_last); end
        vec_cnt++; if (out_idx !== 3'd0) begin err_cnt++; $display("FAIL idle_out_idx: got %0d exp 0", out_idx); end
        settle();
    endtask

    task automatic test_ascending();
        load_vec(1);
        in_valid   = 1'b1;
        descending = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL asc_in_ready: got %0b exp 1", in_ready); end
        settle();
        // Garbage on the inputs and a flipped order must not disturb the vector in flight.
        in_valid   = 1'b0;
        load_vec(200);
        descending = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL asc_valid beat %0d: got %0b exp 1", k, out_valid); end
            vec_cnt++; if (out_data !== W'(k + 1)) begin err_cnt++; $display("FAIL asc_data beat %0d: got %0d exp %0d", k, out_data, k + 1); end
            vec_cnt++; if (out_idx !== IW'(k)) begin err_cnt++; $display("FAIL asc_idx beat %0d: got %0d exp %0d", k, out_idx, k); end
            vec_cnt++; if (out_last !== (k == N - 1)) begin err_cnt++; $display("FAIL asc_last beat %0d: got %0b exp %0b", k, out_last, k == N - 1); end
            vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL asc_busy beat %0d: got %0b exp 1", k, busy); end
            settle();
        end
        @(negedge clk);
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL asc_end_valid: got %0b exp 0", out_valid); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL asc_end_busy: got %0b exp 0", busy); end
        vec_cnt++; if (out_data !== 8'd0) begin err_cnt++; $display("FAIL asc_end_data: got %0d exp 0", out_data); end
        settle();
    endtask

    task automatic test_descending();
        load_vec(1);
        in_valid   = 1'b1;
        descending = 1'b1;
        out_ready  = 1'b1;
        settle();
        in_valid   = 1'b0;
        descending = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL desc_valid beat %0d: got %0b exp 1", k, out_valid); end
            vec_cnt++; if (out_data !== W'(N - k)) begin err_cnt++; $display("FAIL desc_data beat %0d: got %0d exp %0d", k, out_data, N - k); end
            vec_cnt++; if (out_idx !== IW'(k)) begin err_cnt++; $display("FAIL desc_idx beat %0d: got %0d exp %0d", k, out_idx, k); end
            vec_cnt++; if (out_last !== (k == N - 1)) begin err_cnt++; $display("FAIL desc_last beat %0d: got %0b exp %0b", k, out_last, k == N - 1); end
            settle();
        end
        @(negedge clk);
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL desc_end_valid: got %0b exp 0", out_valid); end
        settle();
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        int         expn;
        int         c;
        pat  = 4'b1001;   // out_ready per cycle: 1,0,0,1, repeating
        expn = 0;
        c    = 0;
        load_vec(1);
        in_valid   = 1'b1;
        descending = 1'b0;
        out_ready  = 1'b0;
        settle();
        in_valid = 1'b0;
        while (expn < N && c < 40) begin
            out_ready = pat[c % 4];
            @(negedge clk);
            vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL stall_valid cyc %0d: got %0b exp 1", c, out_valid); end
            vec_cnt++; if (out_data !== W'(expn + 1)) begin err_cnt++; $display("FAIL stall_data cyc %0d: got %0d exp %0d", c, out_data, expn + 1); end
            vec_cnt++; if (out_idx !== IW'(expn)) begin err_cnt++; $display("FAIL stall_idx cyc %0d: got %0d exp %0d", c, out_idx, expn); end
            vec_cnt++; if (out_last !== (expn == N - 1)) begin err_cnt++; $display("FAIL stall_last cyc %0d: got %0b exp %0b", c, out_last, expn == N - 1); end
            vec_cnt++; if (in_ready !== ((expn == N - 1) && out_ready)) begin err_cnt++; $display("FAIL stall_in_ready cyc %0d: got %0b exp %0b", c, in_ready, (expn == N - 1) && out_ready); end
            if (out_ready) expn++;
            c++;
            settle();
        end
        vec_cnt++; if (expn != N) begin err_cnt++; $display("FAIL stall_timeout: got %0d beats exp %0d", expn, N); end
        out_ready = 1'b1;
        @(negedge clk);
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_end_valid: got %0b exp 0", out_valid); end
        settle();
    endtask

    task automatic test_back_to_back();
        load_vec(1);
        in_valid   = 1'b1;
        descending = 1'b0;
        out_ready  = 1'b1;
        settle();
        // Second vector waits with in_valid held high through the first stream.
        load_vec(10);
        in_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            vec_cnt++; if (out_data !== W'(k + 1)) begin err_cnt++; $display("FAIL b2b_first_data beat %0d: got %0d exp %0d", k, out_data, k + 1); end
            vec_cnt++; if (in_ready !== (k == N - 1)) begin err_cnt++; $display("FAIL b2b_in_ready beat %0d: got %0b exp %0b", k, in_ready, k == N - 1); end
            settle();
        end
        in_valid = 1'b0;
        load_vec(100);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_second_valid beat %0d: got %0b exp 1", k, out_valid); end
            vec_cnt++; if (out_data !== W'(10 + k)) begin err_cnt++; $display("FAIL b2b_second_data beat %0d: got %0d exp %0d", k, out_data, 10 + k); end
            vec_cnt++; if (out_idx !== IW'(k)) begin err_cnt++; $display("FAIL b2b_second_idx beat %0d: got %0d exp %0d", k, out_idx, k); end
            settle();
        end
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_end_busy: got %0b exp 0", busy); end
        settle();
    endtask

    task automatic test_reset_mid();
        load_vec(1);
        in_valid   = 1'b1;
        descending = 1'b0;
        out_ready  = 1'b1;
        settle();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec_cnt++; if (out_data !== W'(k + 1)) begin err_cnt++; $display("FAIL rmid_data beat %0d: got %0d exp %0d", k, out_data, k + 1); end
            settle();
        end
        rst = 1'b1;
        settle();
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid: got %0b exp 0", out_valid); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy: got %0b exp 0", busy); end
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rmid_in_ready: got %0b exp 1", in_ready); end
        vec_cnt++; if (out_data !== 8'd0) begin err_cnt++; $display("FAIL rmid_idle_data: got %0d exp 0", out_data); end
        settle();
        // Fresh capture after the reset, descending this time.
        load_vec(1);
        in_valid   = 1'b1;
        descending = 1'b1;
        settle();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            vec_cnt++; if (out_idx !== IW'(k)) begin err_cnt++; $display("FAIL rmid_fresh_idx beat %0d: got %0d exp %0d", k, out_idx, k); end
            vec_cnt++; if (out_data !== W'(N - k)) begin err_cnt++; $display("FAIL rmid_fresh_data beat %0d: got %0d exp %0d", k, out_data, N - k); end
            settle();
        end
        @(negedge clk);
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_fresh_end: got %0b exp 0", out_valid); end
        settle();
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_sort_unloader
